// File: rtl/arith_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared add/sub arithmetic engine.
// The master side drives requests and operands; the slave side returns done strobes and results.
interface arith_share_arbiter_if #(
    parameter int AW = 16,
    parameter int BW = 8
);
    logic          req0;
    logic          op0;
    logic [AW-1:0] a0;
    logic [BW-1:0] b0;
    logic          req1;
    logic          op1;
    logic [AW-1:0] a1;
    logic [BW-1:0] b1;
    logic          done0;
    logic          done1;
    logic [AW-1:0] result;
    logic          ovf;
    logic          err;
    logic          busy;
    logic          gnt;

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        input  done0, done1, result, ovf, err, busy, gnt
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        output done0, done1, result, ovf, err, busy, gnt
    );
endinterface

// File: rtl/arith_share_arbiter.sv
// Round-robin shared iterative multiply (repeated add) / divide (repeated subtract) engine.
// One operation in flight; a one-cycle done strobe goes back to the granted requester.
module arith_share_arbiter #(
    parameter int AW = 16,
    parameter int BW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    arith_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_reg, state_next;
    logic          gnt_reg, gnt_next;
    logic          op_reg, op_next;
    logic [AW-1:0] a_reg, a_next;
    logic [BW-1:0] b_reg, b_next;
    logic [AW-1:0] acc_reg, acc_next;
    logic [BW-1:0] cnt_reg, cnt_next;
    logic [BW-1:0] quo_reg, quo_next;
    logic [AW-1:0] result_reg, result_next;
    logic          ovf_reg, ovf_next;
    logic          err_reg, err_next;

    logic [1:0]    req_v;
    logic [1:0]    op_v;
    logic [AW-1:0] a_v [2];
    logic [BW-1:0] b_v [2];
    logic [1:0]    done_v;
    logic          pick;
    logic [AW:0]   mul_sum;
    logic          div_ge;

    assign req_v  = {bus.req1, bus.req0};
    assign op_v   = {bus.op1, bus.op0};
    assign a_v[0] = bus.a0;
    assign a_v[1] = bus.a1;
    assign b_v[0] = bus.b0;
    assign b_v[1] = bus.b1;

    // On a tie the requester not served last time wins.
    assign pick    = (req_v[0] && req_v[1]) ? ~gnt_reg : req_v[1];
    assign mul_sum = {1'b0, acc_reg} + {1'b0, a_reg};
    assign div_ge  = acc_reg >= {{(AW-BW){1'b0}}, b_reg};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_done
            assign done_v[gi] = (state_reg == S_DONE) && (gnt_reg == 1'(gi));
        end
    endgenerate

    assign bus.done0  = done_v[0];
    assign bus.done1  = done_v[1];
    assign bus.result = result_reg;
    assign bus.ovf    = ovf_reg;
    assign bus.err    = err_reg;
    assign bus.busy   = (state_reg != S_IDLE);
    assign bus.gnt    = gnt_reg;

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        quo_next    = quo_reg;
        result_next = result_reg;
        ovf_next    = ovf_reg;
        err_next    = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (|req_v) begin
                    gnt_next = pick;
                    op_next  = op_v[pick];
                    a_next   = a_v[pick];
                    b_next   = b_v[pick];
                    ovf_next = 1'b0;
                    err_next = 1'b0;
                    if (!op_v[pick]) begin
                        acc_next   = '0;
                        cnt_next   = b_v[pick];
                        state_next = S_RUN;
                    end else if (b_v[pick] == '0) begin
                        err_next    = 1'b1;
                        result_next = '1;
                        state_next  = S_DONE;
                    end else begin
                        acc_next   = a_v[pick];
                        quo_next   = '0;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!op_reg) begin
                    if (cnt_reg != '0) begin
                        acc_next = mul_sum[AW-1:0];
                        ovf_next = ovf_reg | mul_sum[AW];
                        cnt_next = cnt_reg - BW'(1);
                    end else begin
                        result_next = acc_reg;
                        state_next  = S_DONE;
                    end
                end else if (div_ge && (quo_reg != {BW{1'b1}})) begin
                    acc_next = acc_reg - {{(AW-BW){1'b0}}, b_reg};
                    quo_next = quo_reg + BW'(1);
                end else begin
                    // Either the remainder is below the divisor or the quotient saturated.
                    ovf_next    = div_ge;
                    result_next = AW'({acc_reg[BW-1:0], quo_reg});
                    state_next  = S_DONE;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            gnt_reg    <= 1'b1;
            op_reg     <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            quo_reg    <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            quo_reg    <= quo_next;
            result_reg <= result_next;
            ovf_reg    <= ovf_next;
            err_reg    <= err_next;
        end
    end
endmodule

// File: tb/tb_arith_share_arbiter.sv
// Directed and randomized bench for the shared arithmetic arbiter, checked against
// a plain-arithmetic reference of product, quotient/remainder, saturation and latency.
module tb_arith_share_arbiter;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   last_gnt = 1;

    arith_share_arbiter_if bus ();

    arith_share_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result/ovf/err and cycles from sampling edge to done, from the arithmetic itself.
    function automatic void model(input bit op, input int a, input int b,
                                  output int r, output int ov, output int er, output int lat);
        int p;
        int q;
        er = 0;
        ov = 0;
        if (!op) begin
            p   = a * b;
            r   = p % 65536;
            ov  = (p >= 65536) ? 1 : 0;
            lat = b + 2;
        end else if (b == 0) begin
            r   = 16'hFFFF;
            er  = 1;
            lat = 1;
        end else begin
            q = a / b;
            if (q > 255) begin
                r   = (((a - 255 * b) % 256) << 8) | 255;
                ov  = 1;
                lat = 257;
            end else begin
                r   = ((a % b) << 8) | q;
                lat = q + 2;
            end
        end
    endfunction

    function automatic logic done_of(input int who);
        return (who == 0) ? bus.done0 : bus.done1;
    endfunction

    task automatic set_req(input int who, input bit op, input int a, input int b);
        if (who == 0) begin
            bus.req0 = 1'b1; bus.op0 = op; bus.a0 = 16'(a); bus.b0 = 8'(b);
        end else begin
            bus.req1 = 1'b1; bus.op1 = op; bus.a1 = 16'(a); bus.b1 = 8'(b);
        end
    endtask

    // The next rising edge is taken as the sampling edge for this requester's operation.
    task automatic check_op(input int who, input bit op, input int a, input int b, input string tag);
        int r, ov, er, lat, seen;
        model(op, a, b, r, ov, er, lat);
        @(posedge clk); #1;
        seen = 1;
        chk($sformatf("%s.busy", tag), 32'(bus.busy), 32'd1);
        while (!done_of(who) && seen < 400) begin
            @(posedge clk); #1;
            seen++;
        end
        chk($sformatf("%s.lat", tag), seen, lat);
        chk($sformatf("%s.result", tag), 32'(bus.result), r);
        chk($sformatf("%s.ovf", tag), 32'(bus.ovf), ov);
        chk($sformatf("%s.err", tag), 32'(bus.err), er);
        chk($sformatf("%s.gnt", tag), 32'(bus.gnt), who);
        chk($sformatf("%s.other_done", tag), 32'(done_of(1 - who)), 32'd0);
        $display("op %s who=%0d op=%0d a=%h b=%h -> result=%h ovf=%0d err=%0d lat=%0d",
                 tag, who, op, a[15:0], b[7:0], bus.result, bus.ovf, bus.err, seen);
        last_gnt = who;
    endtask

    task automatic release_req(input int who, input string tag);
        @(posedge clk); #1;
        chk($sformatf("%s.done_pulse", tag), 32'(done_of(who)), 32'd0);
        chk($sformatf("%s.idle", tag), 32'(bus.busy), 32'd0);
        if (who == 0) bus.req0 = 1'b0;
        else          bus.req1 = 1'b0;
    endtask

    initial begin
        int r, ov, er, lat, seen, any_done, w, mode;
        int ra0, rb0, ra1, rb1;
        bit rop0, rop1;

        rst = 1'b1;
        bus.req0 = 1'b0; bus.op0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.done0", 32'(bus.done0), 32'd0);
        chk("rst.done1", 32'(bus.done1), 32'd0);
        chk("rst.result", 32'(bus.result), 32'd0);
        chk("rst.ovf", 32'(bus.ovf), 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.gnt", 32'(bus.gnt), 32'd1);
        rst = 1'b0;

        // T1 / T2: plain multiply and divide
        set_req(0, 1'b0, 16'h0123, 5);
        check_op(0, 1'b0, 16'h0123, 5, "t1_mul");
        chk("t1.result_const", 32'(bus.result), 32'h05AF);
        release_req(0, "t1");
        set_req(1, 1'b1, 100, 7);
        check_op(1, 1'b1, 100, 7, "t2_div");
        chk("t2.result_const", 32'(bus.result), 32'h020E);
        release_req(1, "t2");

        // T3: ties right after reset, then alternation
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_gnt = 1;
        set_req(0, 1'b0, 300, 3);
        set_req(1, 1'b1, 50, 6);
        check_op(0, 1'b0, 300, 3, "t3_tie_a");
        release_req(0, "t3a");
        check_op(1, 1'b1, 50, 6, "t3_waiter");
        @(posedge clk); #1;
        set_req(0, 1'b0, 7, 4);
        check_op(0, 1'b0, 7, 4, "t3_tie_b");
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // T4: boundaries
        set_req(0, 1'b1, 16'h1234, 0);
        check_op(0, 1'b1, 16'h1234, 0, "t4_div0");
        release_req(0, "t4a");
        set_req(1, 1'b0, 16'h8000, 2);
        check_op(1, 1'b0, 16'h8000, 2, "t4_mulovf");
        release_req(1, "t4b");
        set_req(0, 1'b1, 16'h2000, 1);
        check_op(0, 1'b1, 16'h2000, 1, "t4_divsat");
        release_req(0, "t4c");
        set_req(1, 1'b0, 16'hBEEF, 0);
        check_op(1, 1'b0, 16'hBEEF, 0, "t4_mulb0");
        release_req(1, "t4d");

        // T5: reset during a long multiply
        set_req(0, 1'b0, 16'h1234, 200);
        any_done = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done0 || bus.done1) any_done = 1;
        end
        chk("t5.no_early_done", any_done, 0);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        chk("t5.busy", 32'(bus.busy), 32'd0);
        chk("t5.gnt", 32'(bus.gnt), 32'd1);
        chk("t5.done0", 32'(bus.done0), 32'd0);
        chk("t5.result", 32'(bus.result), 32'd0);
        rst = 1'b0;
        last_gnt = 1;
        set_req(0, 1'b0, 16'h0042, 3);
        check_op(0, 1'b0, 16'h0042, 3, "t5_after");
        release_req(0, "t5");

        // T6: operands change and request drops mid-run
        model(1'b0, 16'h0123, 9, r, ov, er, lat);
        set_req(0, 1'b0, 16'h0123, 9);
        @(posedge clk); #1;
        seen = 1;
        bus.a0 = 16'hFFFF;
        bus.b0 = 8'd3;
        bus.req0 = 1'b0;
        while (!bus.done0 && seen < 400) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("t6.lat", seen, lat);
        chk("t6.result", 32'(bus.result), r);
        chk("t6.ovf", 32'(bus.ovf), ov);
        $display("op t6_latched a=0123 b=09 -> result=%h lat=%0d", bus.result, seen);
        @(posedge clk); #1;

        // Randomized traffic, including ties served in round-robin order
        for (int i = 0; i < 20; i++) begin
            mode = $urandom_range(0, 2);
            rop0 = 1'($urandom_range(0, 1));
            rop1 = 1'($urandom_range(0, 1));
            ra0 = $urandom_range(0, 65535);
            ra1 = $urandom_range(0, 65535);
            rb0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            rb1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            if (mode == 0) begin
                set_req(0, rop0, ra0, rb0);
                check_op(0, rop0, ra0, rb0, $sformatf("rnd%0d", i));
                release_req(0, $sformatf("rnd%0d", i));
            end else if (mode == 1) begin
                set_req(1, rop1, ra1, rb1);
                check_op(1, rop1, ra1, rb1, $sformatf("rnd%0d", i));
                release_req(1, $sformatf("rnd%0d", i));
            end else begin
                set_req(0, rop0, ra0, rb0);
                set_req(1, rop1, ra1, rb1);
                w = (last_gnt == 0) ? 1 : 0;
                if (w == 0) check_op(0, rop0, ra0, rb0, $sformatf("rnd%0d_first", i));
                else        check_op(1, rop1, ra1, rb1, $sformatf("rnd%0d_first", i));
                release_req(w, $sformatf("rnd%0d_first", i));
                if (w == 0) check_op(1, rop1, ra1, rb1, $sformatf("rnd%0d_second", i));
                else        check_op(0, rop0, ra0, rb0, $sformatf("rnd%0d_second", i));
                release_req(1 - w, $sformatf("rnd%0d_second", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
